// File: rtl/pe_pipe_pkg.sv
// Shared widths, control bundle and sizing helper for the PE I/O retiming harness.
package pe_pipe_pkg;

  localparam int unsigned DEF_A_W     = 8;
  localparam int unsigned DEF_B_W     = 19;
  localparam int unsigned DEF_D_W     = 71;
  localparam int unsigned DEF_C_W     = 71;
  localparam int unsigned DEF_SHIFT_W = 5;

  typedef struct packed {
    logic                   valid;
    logic [DEF_SHIFT_W-1:0] shift;
    logic                   propagate;
  } ctrl_t;

  // Bits needed to count 0..stages set valid bits.
  function automatic int unsigned occ_w(input int unsigned stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pe_pipe_stage.sv
// One retiming register stage: a valid bit plus a flat data/control payload.
module pe_pipe_stage #(
  parameter int unsigned W            = 8,
  parameter bit          HOLD_INVALID = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         flush_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    // NOTE: every output of this block is given a hold value first, so no path can infer a latch.
    valid_d = valid_q;
    data_d  = data_q;
    if (en_i) begin
      valid_d = valid_i;
      // Flush clears only the valid bit; the payload is left as it was.
      if (!flush_i && (valid_i || !HOLD_INVALID)) data_d = data_i;
    end
    if (flush_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state updates use non-blocking assignments so all stages sample the old values together.
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pe_io_pipe.sv
// Configurable input/output retiming around one mesh PE, with stall, flush,
// occupancy and a saturating output-token counter. No arithmetic lives here.
module pe_io_pipe
  import pe_pipe_pkg::*;
#(
  parameter int unsigned A_W          = DEF_A_W,
  parameter int unsigned B_W          = DEF_B_W,
  parameter int unsigned D_W          = DEF_D_W,
  parameter int unsigned C_W          = DEF_C_W,
  parameter int unsigned SHIFT_W      = DEF_SHIFT_W,
  parameter int unsigned IN_STAGES    = 1,
  parameter int unsigned OUT_STAGES   = 1,
  parameter bit          HOLD_INVALID = 1'b1,
  parameter int unsigned PERF_W       = 32
) (
  input  logic                                         CLK,
  input  logic                                         RST,
  input  logic                                         en,
  input  logic                                         flush,
  input  logic                                         cnt_clr,
  input  logic [A_W-1:0]                               in_a,
  input  logic [B_W-1:0]                               in_b,
  input  logic [D_W-1:0]                               in_d,
  input  logic                                         in_valid,
  input  logic [SHIFT_W-1:0]                           in_shift,
  input  logic                                         in_propagate,
  output logic [A_W-1:0]                               pe_in_a,
  output logic [B_W-1:0]                               pe_in_b,
  output logic [D_W-1:0]                               pe_in_d,
  output logic                                         pe_in_valid,
  output logic [SHIFT_W-1:0]                           pe_in_shift,
  output logic                                         pe_in_propagate,
  input  logic [A_W-1:0]                               pe_out_a,
  input  logic [B_W-1:0]                               pe_out_b,
  input  logic [C_W-1:0]                               pe_out_c,
  input  logic                                         pe_out_valid,
  input  logic [SHIFT_W-1:0]                           pe_out_shift,
  input  logic                                         pe_out_propagate,
  output logic [A_W-1:0]                               out_a,
  output logic [B_W-1:0]                               out_b,
  output logic [C_W-1:0]                               out_c,
  output logic                                         out_valid,
  output logic [SHIFT_W-1:0]                           out_shift,
  output logic                                         out_propagate,
  output logic [occ_w(IN_STAGES+OUT_STAGES)-1:0]       occupancy,
  output logic [PERF_W-1:0]                            perf_cnt
);

  localparam int unsigned IN_W  = A_W + B_W + D_W + SHIFT_W + 1;
  localparam int unsigned OUT_W = A_W + B_W + C_W + SHIFT_W + 1;
  localparam int unsigned OCC_W = occ_w(IN_STAGES + OUT_STAGES);

  // Index 0 is the chain input; index N is the last stage register.
  logic [IN_STAGES:0]  in_vld;
  logic [IN_W-1:0]     in_dat  [IN_STAGES+1];
  logic [OUT_STAGES:0] out_vld;
  logic [OUT_W-1:0]    out_dat [OUT_STAGES+1];

  assign in_vld[0]  = in_valid;
  assign in_dat[0]  = {in_a, in_b, in_d, in_shift, in_propagate};
  assign out_vld[0] = pe_out_valid;
  assign out_dat[0] = {pe_out_a, pe_out_b, pe_out_c, pe_out_shift, pe_out_propagate};

  for (genvar i = 0; i < IN_STAGES; i++) begin : g_in
    pe_pipe_stage #(.W(IN_W), .HOLD_INVALID(HOLD_INVALID)) u_stage (
      .clk(CLK), .rst_n(RST), .en_i(en), .flush_i(flush),
      .valid_i(in_vld[i]),   .data_i(in_dat[i]),
      .valid_o(in_vld[i+1]), .data_o(in_dat[i+1])
    );
  end

  for (genvar i = 0; i < OUT_STAGES; i++) begin : g_out
    pe_pipe_stage #(.W(OUT_W), .HOLD_INVALID(HOLD_INVALID)) u_stage (
      .clk(CLK), .rst_n(RST), .en_i(en), .flush_i(flush),
      .valid_i(out_vld[i]),   .data_i(out_dat[i]),
      .valid_o(out_vld[i+1]), .data_o(out_dat[i+1])
    );
  end

  assign {pe_in_a, pe_in_b, pe_in_d, pe_in_shift, pe_in_propagate} = in_dat[IN_STAGES];
  assign pe_in_valid = in_vld[IN_STAGES];
  assign {out_a, out_b, out_c, out_shift, out_propagate} = out_dat[OUT_STAGES];
  assign out_valid   = out_vld[OUT_STAGES];

  assign occupancy = OCC_W'($countones({in_vld[IN_STAGES:1], out_vld[OUT_STAGES:1]}));

  logic [PERF_W-1:0] perf_q, perf_d;

  // Clear beats increment; the count sticks at all-ones instead of wrapping.
  always_comb begin
    perf_d = perf_q;
    if (cnt_clr)                                perf_d = '0;
    else if (en && out_valid && (perf_q != '1)) perf_d = perf_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) perf_q <= '0;
    else      perf_q <= perf_d;
  end

  assign perf_cnt = perf_q;

endmodule

// File: tb/tb_pe_io_pipe.sv
// Scoreboard bench for pe_io_pipe with the PE replaced by a pe_in_* -> pe_out_* loopback.
module tb_pe_io_pipe;
  import pe_pipe_pkg::*;

  localparam int unsigned A_W     = DEF_A_W;
  localparam int unsigned B_W     = DEF_B_W;
  localparam int unsigned D_W     = DEF_D_W;
  localparam int unsigned C_W     = DEF_C_W;
  localparam int unsigned SHIFT_W = DEF_SHIFT_W;
  localparam int unsigned PERF_W  = 4;
  localparam int unsigned OCC_W   = occ_w(5);

  typedef struct packed {
    logic [A_W-1:0]     a;
    logic [B_W-1:0]     b;
    logic [C_W-1:0]     c;
    logic [SHIFT_W-1:0] shift;
    logic               prop;
  } tok_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic en, flush, cnt_clr;
  logic [A_W-1:0] in_a;
  logic [B_W-1:0] in_b;
  logic [D_W-1:0] in_d;
  ctrl_t          in_ctrl;

  logic [A_W-1:0] pe_in_a;   logic [B_W-1:0] pe_in_b;   logic [D_W-1:0] pe_in_d;
  logic pe_in_valid, pe_in_propagate;  logic [SHIFT_W-1:0] pe_in_shift;
  logic [A_W-1:0] out_a;     logic [B_W-1:0] out_b;     logic [C_W-1:0] out_c;
  logic out_valid, out_propagate;      logic [SHIFT_W-1:0] out_shift;
  logic [OCC_W-1:0]  occupancy;
  logic [PERF_W-1:0] perf_cnt;

  logic [A_W-1:0] l_pe_in_a; logic [B_W-1:0] l_pe_in_b; logic [D_W-1:0] l_pe_in_d;
  logic l_pe_in_valid, l_pe_in_propagate; logic [SHIFT_W-1:0] l_pe_in_shift;
  logic [A_W-1:0] l_out_a;   logic [B_W-1:0] l_out_b;   logic [C_W-1:0] l_out_c;
  logic l_out_valid, l_out_propagate;   logic [SHIFT_W-1:0] l_out_shift;
  logic [occ_w(2)-1:0] l_occupancy;
  logic [31:0]         l_perf_cnt;

  pe_io_pipe #(.IN_STAGES(3), .OUT_STAGES(2), .HOLD_INVALID(1'b1), .PERF_W(PERF_W)) u_dut (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush), .cnt_clr(cnt_clr),
    .in_a(in_a), .in_b(in_b), .in_d(in_d), .in_valid(in_ctrl.valid),
    .in_shift(in_ctrl.shift), .in_propagate(in_ctrl.propagate),
    .pe_in_a(pe_in_a), .pe_in_b(pe_in_b), .pe_in_d(pe_in_d), .pe_in_valid(pe_in_valid),
    .pe_in_shift(pe_in_shift), .pe_in_propagate(pe_in_propagate),
    .pe_out_a(pe_in_a), .pe_out_b(pe_in_b), .pe_out_c(pe_in_d), .pe_out_valid(pe_in_valid),
    .pe_out_shift(pe_in_shift), .pe_out_propagate(pe_in_propagate),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_valid(out_valid),
    .out_shift(out_shift), .out_propagate(out_propagate),
    .occupancy(occupancy), .perf_cnt(perf_cnt)
  );

  pe_io_pipe #(.IN_STAGES(1), .OUT_STAGES(1), .HOLD_INVALID(1'b0)) u_legacy (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush), .cnt_clr(cnt_clr),
    .in_a(in_a), .in_b(in_b), .in_d(in_d), .in_valid(in_ctrl.valid),
    .in_shift(in_ctrl.shift), .in_propagate(in_ctrl.propagate),
    .pe_in_a(l_pe_in_a), .pe_in_b(l_pe_in_b), .pe_in_d(l_pe_in_d), .pe_in_valid(l_pe_in_valid),
    .pe_in_shift(l_pe_in_shift), .pe_in_propagate(l_pe_in_propagate),
    .pe_out_a(l_pe_in_a), .pe_out_b(l_pe_in_b), .pe_out_c(l_pe_in_d), .pe_out_valid(l_pe_in_valid),
    .pe_out_shift(l_pe_in_shift), .pe_out_propagate(l_pe_in_propagate),
    .out_a(l_out_a), .out_b(l_out_b), .out_c(l_out_c), .out_valid(l_out_valid),
    .out_shift(l_out_shift), .out_propagate(l_out_propagate),
    .occupancy(l_occupancy), .perf_cnt(l_perf_cnt)
  );

  always #5 CLK = ~CLK;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_tx = 0;
  int   n_rx = 0;
  tok_t exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input logic [D_W-1:0] d,
                      input logic [SHIFT_W-1:0] sh, input logic prop, input bit expect_out);
    tok_t t;
    in_a = a; in_b = b; in_d = d;
    in_ctrl.valid = 1'b1; in_ctrl.shift = sh; in_ctrl.propagate = prop;
    if (expect_out) begin
      t.a = a; t.b = b; t.c = d; t.shift = sh; t.prop = prop;
      exp_q.push_back(t);
      n_tx++;
    end
  endtask

  task automatic idle();
    in_ctrl.valid = 1'b0;
  endtask

  // Monitor: a token leaves the output on each edge where en=1 and out_valid=1.
  always @(negedge CLK) begin
    tok_t e;
    if (RST && en && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_token", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        n_rx++;
        check("token", {out_a, out_b, out_c, out_shift, out_propagate}, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (errors so far %0d)", n_errors);
    $fatal(1);
  end

  initial begin
    en = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
    in_a = '0; in_b = '0; in_d = '0; in_ctrl = '0;
    step(2);
    check("rst_pe_in_a", pe_in_a, 0);
    check("rst_pe_in_valid", pe_in_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_c", out_c, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_perf_cnt", perf_cnt, 0);
    RST = 1'b1;

    // Latency: 3 cycles to pe_in_*, 5 cycles to out_* through the loopback.
    send(8'h5A, 19'h1234, 71'h12_3456_789A_BCDE_F012, 5'h03, 1'b1, 1'b1);
    step(); idle();
    check("lat_c1_pe_in_valid", pe_in_valid, 0);
    step();
    check("lat_c2_pe_in_valid", pe_in_valid, 0);
    check("lat_c2_pe_in_a", pe_in_a, 0);
    step();
    check("lat_c3_pe_in_valid", pe_in_valid, 1);
    check("lat_c3_pe_in_a", pe_in_a, 8'h5A);
    check("lat_c3_out_valid", out_valid, 0);
    step();
    check("lat_c4_out_valid", out_valid, 0);
    step();
    check("lat_c5_out_valid", out_valid, 1);
    check("lat_c5_out_a", out_a, 8'h5A);
    check("lat_c5_occupancy", occupancy, 1);
    step(3);

    // Hold: valid-gated capture keeps 11; legacy load-always follows FF.
    send(8'h11, 19'h00022, 71'h33, 5'h04, 1'b0, 1'b1);
    step(); idle(); in_a = 8'hFF;
    check("legacy_pe_in_a_tok", l_pe_in_a, 8'h11);
    step();
    check("legacy_pe_in_a_follow", l_pe_in_a, 8'hFF);
    step(4);
    check("hold_pe_in_a", pe_in_a, 8'h11);
    check("hold_pe_in_valid", pe_in_valid, 0);
    step(4);
    check("hold_out_a", out_a, 8'h11);
    check("hold_out_valid", out_valid, 0);

    // Stall: two tokens frozen in place while junk is offered at the input.
    send(8'hA1, 19'h0A1A1, 71'hA1, 5'h0A, 1'b1, 1'b1);
    step();
    send(8'hB2, 19'h0B2B2, 71'hB2, 5'h0B, 1'b0, 1'b1);
    step(); idle();
    step();
    en = 1'b0;
    send(8'hEE, 19'h0EEEE, 71'hEE, 5'h1E, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_occupancy", occupancy, 2);
      check("stall_pe_in_valid", pe_in_valid, 1);
      check("stall_pe_in_a", pe_in_a, 8'hA1);
      check("stall_out_valid", out_valid, 0);
    end
    idle(); en = 1'b1;
    step(8);

    // Flush: three in flight plus a fourth offered with flush; none may emerge.
    send(8'hC1, 19'h1, 71'h1, 5'h01, 1'b0, 1'b0); step();
    send(8'hC2, 19'h2, 71'h2, 5'h02, 1'b0, 1'b0); step();
    send(8'hC3, 19'h3, 71'h3, 5'h03, 1'b0, 1'b0); step();
    send(8'hC4, 19'h4, 71'h4, 5'h04, 1'b0, 1'b0); flush = 1'b1;
    step();
    flush = 1'b0; idle();
    check("flush_occupancy", occupancy, 0);
    check("flush_pe_in_valid", pe_in_valid, 0);
    step(8);

    // Perf counter: four tokens so far, then clear, then 20 tokens saturate at F.
    check("perf_after_4", perf_cnt, 4'h4);
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    check("perf_cleared", perf_cnt, 4'h0);
    for (int i = 0; i < 20; i++) begin
      send(A_W'(8'h20 + i), B_W'(i * 3), D_W'(i * 1000), SHIFT_W'(i), i[0], 1'b1);
      step();
    end
    idle();
    step(8);
    check("perf_saturated", perf_cnt, 4'hF);

    // Clear coincident with an output token: clear wins.
    send(8'h77, 19'h7, 71'h77, 5'h07, 1'b1, 1'b1);
    step(); idle();
    step(4);
    check("clr_tok_out_valid", out_valid, 1);
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    check("clr_tok_perf", perf_cnt, 4'h0);
    step();
    check("clr_tok_perf_after", perf_cnt, 4'h0);

    // Asynchronous reset mid-cycle with two tokens in the output stages.
    send(8'hD1, 19'hD1, 71'hD1, 5'h11, 1'b0, 1'b0); step();
    send(8'hD2, 19'hD2, 71'hD2, 5'h12, 1'b1, 1'b0); step(); idle();
    step(3);
    check("arst_pre_out_valid", out_valid, 1);
    check("arst_pre_occupancy", occupancy, 2);
    #2 RST = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_occupancy", occupancy, 0);
    check("arst_out_a", out_a, 0);
    check("arst_perf_cnt", perf_cnt, 0);
    step(2);
    RST = 1'b1;
    step(10);
    check("arst_after_occupancy", occupancy, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    check("token_count", n_rx, n_tx);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
